step_seq_checker: RTL and testbench
===================================

Name: step_seq_checker

Overview:
- Passive monitor and checker for the probe bus of the step-sequencer experiment: sq_c1, sq_x, sq_i, sq_act.
- Runs a cycle-accurate internal model of the sequencer from the same clock and reset, and compares the probe values against the model every cycle.
- Flags, counts and captures mismatches so they can be read on the logic analyser or LEDs.
- Sits beside the sequencer at board top level and consumes its probe outputs.

Parameters:
- STEP_LEN, 10, number of cycles spent in step 0 per pass (c1 terminal value is STEP_LEN-1).
- RELOAD_C1, 10, value loaded into c1 by step 1.
- RELOAD_X, 20, value loaded into x by step 1.
- RELOAD_ACT, 30, value loaded into act by step 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; must be the same reset that drives the sequencer.
- sq_c1  in  8  probe: sequencer c1.
- sq_x  in  8  probe: sequencer x.
- sq_i  in  2  probe: sequencer step index.
- sq_act  in  8  probe: sequencer act.
- chk_en  in  1  compare enable; the model runs regardless of this input.
- mism  out  1  registered one-cycle pulse per mismatching cycle.
- err  out  1  sticky error flag.
- err_cnt  out  16  count of mismatching cycles, saturating.
- err_field  out  4  {i,act,x,c1} mismatch bits captured at the first error.
- first_cyc  out  16  cycle index of the first error.

Behaviour:
- Reset (async, active-low): model m_c1=m_x=m_act=0, m_i=0; cyc=0; mism=0, err=0, err_cnt=0, err_field=0, first_cyc=0.
- Model update on each rising edge, using old values:
  - m_i==0:
    - if m_x==m_c1, then m_x+1 and m_act+1.
    - if m_c1==STEP_LEN-1, then m_c1=0, m_x=0 (overrides the x increment), m_i=1. m_act still increments if the equality held.
    - else m_c1+1.
  - m_i==1: m_i=0, m_c1=RELOAD_C1, m_x=RELOAD_X, m_act=RELOAD_ACT.
  - m_i==2 or 3: hold all values (unreachable).
- Arithmetic: all fields are 8-bit, modulo 256, no saturation (c1 and x wrap 255->0).
- cyc: 16-bit, 0 during the first cycle after reset release, +1 per edge, saturates at 0xFFFF.
- Compare (combinational): diff[3:0] = {sq_i!=m_i, sq_act!=m_act, sq_x!=m_x, sq_c1!=m_c1}; hit = chk_en & |diff.
- Registered outputs (1-cycle latency): mism <= hit.
- On hit:
  - err_cnt+1, saturating at 0xFFFF.
  - If err==0: err<=1, err_field<=diff, first_cyc<=cyc.
  - err_field and first_cyc are frozen once err=1; only reset clears them.
- chk_en low: no counting or capture; mism=0 next cycle; the model stays aligned.
- Reset mid-run: everything returns to reset values immediately. The sequencer must be reset simultaneously; otherwise the checker reports mismatches by design.
- Probe sq_i of 2 or 3 while the model is at 0 or 1 counts as an i-field mismatch.

Test Plan:
- Golden sequencer, chk_en=1, run 600 cycles -> mism never asserts, err=0, err_cnt=0. Cycle k=0..9: c1=x=act=k, i=0. Cycle 10: c1=0, x=0, act=10, i=1. Cycle 11: c1=10, x=20, act=30. Cycle 22: x=21, act=31.
- Force sq_x=5 during cycle 7 only -> mism=1 in cycle 8; err=1; err_field=4'b0010; first_cyc=7; err_cnt=1.
- Force sq_act=0 for cycles 11-13, then sq_i=1 at cycle 20 -> err_cnt=4; err_field=4'b0100, first_cyc=11, unchanged by the later error.
- chk_en=0 for cycles 0-15 with corrupted probes, then a golden bus -> err=0, err_cnt=0; after chk_en=1, errors injected at cycle 30 are detected with first_cyc=30.
- Constant mismatch for 70000 cycles -> err_cnt saturates at 0xFFFF; first_cyc=0.
- Assert rst_n low mid-run at cycle 50 for 3 cycles -> all outputs 0 asynchronously; after release the model restarts at c1=x=act=0, i=0 and the golden bus passes.

Source files
------------

// File: rtl/step_seq_checker.sv
// ---------------------------------------------------------------------------
// step_seq_checker
//
// Passive monitor for the step-sequencer probe bus. A cycle-accurate copy of
// the sequencer runs from the same clock and reset; every cycle the probe
// values are compared against it. Mismatches are pulsed, counted and the
// first one is captured for the logic analyser / LEDs.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset (shared with the sequencer)
//   sq_c1      probe: sequencer c1          (8 bit)
//   sq_x       probe: sequencer x           (8 bit)
//   sq_i       probe: sequencer step index  (2 bit)
//   sq_act     probe: sequencer act         (8 bit)
//   chk_en     compare enable; the internal model runs regardless
//   mism       registered one-cycle pulse per mismatching cycle
//   err        sticky error flag
//   err_cnt    saturating count of mismatching cycles
//   err_field  {i,act,x,c1} mismatch bits captured at the first error
//   first_cyc  cycle index of the first error
// ---------------------------------------------------------------------------
module step_seq_checker #(
  parameter int unsigned STEP_LEN   = 10,
  parameter int unsigned RELOAD_C1  = 10,
  parameter int unsigned RELOAD_X   = 20,
  parameter int unsigned RELOAD_ACT = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sq_c1,
  input  logic [7:0]  sq_x,
  input  logic [1:0]  sq_i,
  input  logic [7:0]  sq_act,
  input  logic        chk_en,
  output logic        mism,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [3:0]  err_field,
  output logic [15:0] first_cyc
);

  localparam logic [7:0] C1_LAST  = 8'(STEP_LEN - 1);
  localparam logic [7:0] LD_C1    = 8'(RELOAD_C1);
  localparam logic [7:0] LD_X     = 8'(RELOAD_X);
  localparam logic [7:0] LD_ACT   = 8'(RELOAD_ACT);
  localparam logic [15:0] SAT16   = 16'hFFFF;

  // Model of the sequencer state
  logic [7:0] m_c1, m_x, m_act;
  logic [1:0] m_i;
  logic [7:0] nm_c1, nm_x, nm_act;
  logic [1:0] nm_i;

  logic [15:0] cyc;
  logic [3:0]  diff;
  logic        hit;

  // Next-state of the model, always computed from the old values.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    nm_c1  = m_c1;
    nm_x   = m_x;
    nm_act = m_act;
    nm_i   = m_i;
    unique case (m_i)
      2'd0: begin
        if (m_x == m_c1) begin
          nm_x   = m_x + 8'd1;
          nm_act = m_act + 8'd1;
        end
        if (m_c1 == C1_LAST) begin
          // End of step 0: x clear wins over the x increment; act keeps it.
          nm_c1 = 8'd0;
          nm_x  = 8'd0;
          nm_i  = 2'd1;
        end else begin
          nm_c1 = m_c1 + 8'd1;
        end
      end
      2'd1: begin
        nm_i   = 2'd0;
        nm_c1  = LD_C1;
        nm_x   = LD_X;
        nm_act = LD_ACT;
      end
      default: ; // steps 2/3 are unreachable in the sequencer: hold
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      m_c1  <= 8'd0;
      m_x   <= 8'd0;
      m_act <= 8'd0;
      m_i   <= 2'd0;
    end else begin
      m_c1  <= nm_c1;
      m_x   <= nm_x;
      m_act <= nm_act;
      m_i   <= nm_i;
    end
  end

  // Probe comparison against the model's current state
  assign diff = {sq_i != m_i, sq_act != m_act, sq_x != m_x, sq_c1 != m_c1};
  assign hit  = chk_en & (|diff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 16'd0;
      mism      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= 16'd0;
      err_field <= 4'd0;
      first_cyc <= 16'd0;
    end else begin
      if (cyc != SAT16) cyc <= cyc + 16'd1;
      mism <= hit;
      if (hit) begin
        if (err_cnt != SAT16) err_cnt <= err_cnt + 16'd1;
        // Capture only the first error; later hits leave the snapshot alone.
        if (!err) begin
          err       <= 1'b1;
          err_field <= diff;
          first_cyc <= cyc;
        end
      end
    end
  end

endmodule

// File: tb/tb_step_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_step_seq_checker
//
// Drives the probe bus from a behavioural sequencer reference, optionally
// corrupting fields, and checks the checker's outputs every cycle against a
// scoreboard of the expected flag/count/capture state.
// ---------------------------------------------------------------------------
module tb_step_seq_checker;

  localparam int STEP_LEN   = 10;
  localparam int RELOAD_C1  = 10;
  localparam int RELOAD_X   = 20;
  localparam int RELOAD_ACT = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  sq_c1 = '0, sq_x = '0, sq_act = '0;
  logic [1:0]  sq_i = '0;
  logic        chk_en = 1'b0;
  logic        mism, err;
  logic [15:0] err_cnt, first_cyc;
  logic [3:0]  err_field;

  int checks = 0;
  int errors = 0;

  // Reference sequencer state (plain integers, modulo-256 arithmetic)
  int g_c1, g_x, g_act, g_i;
  // Scoreboard of expected checker outputs
  int e_mism, e_err, e_cnt, e_field, e_first, e_cyc;

  step_seq_checker #(
    .STEP_LEN(STEP_LEN), .RELOAD_C1(RELOAD_C1),
    .RELOAD_X(RELOAD_X), .RELOAD_ACT(RELOAD_ACT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sq_c1(sq_c1), .sq_x(sq_x), .sq_i(sq_i), .sq_act(sq_act),
    .chk_en(chk_en),
    .mism(mism), .err(err), .err_cnt(err_cnt),
    .err_field(err_field), .first_cyc(first_cyc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    g_c1 = 0; g_x = 0; g_act = 0; g_i = 0;
    e_mism = 0; e_err = 0; e_cnt = 0; e_field = 0; e_first = 0; e_cyc = 0;
  endtask

  // One sequencer step from the rules: step 0 counts c1 up to STEP_LEN-1 with
  // x/act chasing c1, step 1 reloads and returns to step 0.
  task automatic model_advance();
    bit eq;
    if (g_i == 0) begin
      eq = (g_x == g_c1);
      if (eq) g_act = (g_act + 1) % 256;
      if (g_c1 == STEP_LEN - 1) begin
        g_c1 = 0; g_x = 0; g_i = 1;
      end else begin
        g_c1 = (g_c1 + 1) % 256;
        if (eq) g_x = (g_x + 1) % 256;
      end
    end else if (g_i == 1) begin
      g_i = 0; g_c1 = RELOAD_C1; g_x = RELOAD_X; g_act = RELOAD_ACT;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_mism"},  32'(mism),      32'(e_mism));
    check({tag, "_err"},   32'(err),       32'(e_err));
    check({tag, "_cnt"},   32'(err_cnt),   32'(e_cnt));
    check({tag, "_field"}, 32'(err_field), 32'(e_field));
    check({tag, "_first"}, 32'(first_cyc), 32'(e_first));
  endtask

  // One clock cycle: fields selected by fmask are driven with the given
  // values, the rest with the reference values.
  task automatic step(input bit en, input bit [3:0] fmask,
                      input logic [7:0] v_c1, input logic [7:0] v_x,
                      input logic [7:0] v_act, input logic [1:0] v_i,
                      input string tag);
    int d;
    bit h;
    @(negedge clk);
    chk_en = en;
    sq_c1  = fmask[0] ? v_c1  : 8'(g_c1);
    sq_x   = fmask[1] ? v_x   : 8'(g_x);
    sq_act = fmask[2] ? v_act : 8'(g_act);
    sq_i   = fmask[3] ? v_i   : 2'(g_i);
    d = {28'd0, int'(sq_i) != g_i, int'(sq_act) != g_act,
         int'(sq_x) != g_x, int'(sq_c1) != g_c1};
    h = en && (d != 0);
    @(posedge clk);
    #1;
    e_mism = h;
    if (h) begin
      if (e_cnt < 16'hFFFF) e_cnt++;
      if (!e_err) begin
        e_err = 1; e_field = d; e_first = e_cyc;
      end
    end
    if (e_cyc < 16'hFFFF) e_cyc++;
    model_advance();
    check_outputs(tag);
  endtask

  task automatic golden(input bit en, input string tag);
    step(en, 4'b0000, 8'd0, 8'd0, 8'd0, 2'd0, tag);
  endtask

  // Corrupt the selected fields to values guaranteed to differ.
  task automatic corrupt(input bit en, input bit [3:0] fmask, input string tag);
    step(en, fmask,
         8'(g_c1 ^ $urandom_range(1, 255)), 8'(g_x ^ $urandom_range(1, 255)),
         8'(g_act ^ $urandom_range(1, 255)), 2'(g_i ^ $urandom_range(1, 3)), tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    // Reset state
    do_reset();
    check_outputs("reset");

    // Golden bus for 600 cycles: no error may appear
    for (int k = 0; k < 600; k++) golden(1'b1, "golden");
    check("golden_err_end", 32'(err), 32'd0);
    check("golden_cnt_end", 32'(err_cnt), 32'd0);

    // Single x glitch at cycle 7
    do_reset();
    for (int k = 0; k < 12; k++)
      step(1'b1, (k == 7) ? 4'b0010 : 4'b0000, 8'd0, 8'd5, 8'd0, 2'd0, "xglitch");
    check("xglitch_field", 32'(err_field), 32'h2);
    check("xglitch_first", 32'(first_cyc), 32'd7);
    check("xglitch_cnt", 32'(err_cnt), 32'd1);

    // act forced to 0 for cycles 11-13, then i forced to 1 at cycle 20
    do_reset();
    for (int k = 0; k < 26; k++)
      step(1'b1, (k >= 11 && k <= 13) ? 4'b0100 : (k == 20 ? 4'b1000 : 4'b0000),
           8'd0, 8'd0, 8'd0, 2'd1, "act_i");
    check("act_i_cnt", 32'(err_cnt), 32'd4);
    check("act_i_field", 32'(err_field), 32'h4);
    check("act_i_first", 32'(first_cyc), 32'd11);

    // Compare disabled over corrupted probes, then detection at cycle 30
    do_reset();
    for (int k = 0; k < 16; k++) corrupt(1'b0, 4'hF, "chkoff");
    check("chkoff_err", 32'(err), 32'd0);
    check("chkoff_cnt", 32'(err_cnt), 32'd0);
    for (int k = 16; k < 30; k++) golden(1'b1, "chkon");
    corrupt(1'b1, 4'($urandom_range(1, 15)), "inject30");
    for (int k = 31; k < 36; k++) golden(1'b1, "after30");
    check("inject30_first", 32'(first_cyc), 32'd30);
    check("inject30_err", 32'(err), 32'd1);

    // Randomised enable and corruption against the scoreboard
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0)
        corrupt($urandom_range(0, 3) != 0, 4'($urandom_range(1, 15)), "random");
      else
        golden($urandom_range(0, 3) != 0, "random");
    end

    // Mid-run asynchronous reset at cycle 50 with an earlier error latched
    do_reset();
    for (int k = 0; k < 50; k++)
      if (k == 5) corrupt(1'b1, 4'b0001, "prerst"); else golden(1'b1, "prerst");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 100; k++) golden(1'b1, "postrst");
    check("postrst_err", 32'(err), 32'd0);

    // Constant i mismatch for 70000 cycles: counter saturates
    do_reset();
    for (int k = 0; k < 70000; k++)
      step(1'b1, 4'b1000, 8'd0, 8'd0, 8'd0, 2'd3, "sat");
    check("sat_cnt", 32'(err_cnt), 32'hFFFF);
    check("sat_first", 32'(first_cyc), 32'd0);
    check("sat_field", 32'(err_field), 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
